item_selector_queue: RTL and testbench

Buffered, parametrised successor to the single-item selector. Accepts item selections from the keypad/front-end over a valid/ready handshake and range-checks them against `NUM_ITEMS`. Legal selections are queued in a `DEPTH`-entry FIFO and presented in order to the dispense controller over a second valid/ready handshake. Adds a stall timeout that drops unaccepted selections, a cancel/flush input, and error reporting.

---
 rtl/item_selector_queue.sv | 141 ++++++++++++++
 tb/tb_item_selector_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/item_selector_queue.sv
`default_nettype none
// ============================================================================
// Module : item_selector_queue
// Brief  : Range-checked item selection FIFO with stall timeout and cancel.
// Rev    : 1.0  initial release
// ============================================================================
module item_selector_queue #(
    parameter int ITEM_ADDR_WIDTH = 10,
    parameter int NUM_ITEMS       = 1000,
    parameter int DEPTH           = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ITEM_ADDR_WIDTH-1:0]    item_select,
    input  logic                          item_select_valid,
    output logic                          item_select_ready,
    input  logic                          cancel,
    output logic [ITEM_ADDR_WIDTH-1:0]    selected_item,
    output logic                          selection_valid,
    input  logic                          selection_ready,
    output logic                          select_error,
    output logic                          timeout_drop,
    output logic [$clog2(DEPTH+1)-1:0]    pending_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);
    localparam logic [c_cnt_w-1:0]         c_depth        = c_cnt_w'(DEPTH);
    localparam logic [ITEM_ADDR_WIDTH:0]   c_num_items    = (ITEM_ADDR_WIDTH+1)'(NUM_ITEMS);
    localparam logic [15:0]                c_timeout_last = 16'(TIMEOUT - 1);
    localparam logic                       c_timeout_en   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_ACTIVE = 2'd1,
        S_FULL   = 2'd2
    } occ_t;

    occ_t                         r_state;
    occ_t                         w_next_state;
    logic [ITEM_ADDR_WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0]           r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w-1:0]           w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [c_cnt_w-1:0]           r_count, w_count_nxt;
    logic [15:0]                  r_stall, w_stall_nxt;
    logic [ITEM_ADDR_WIDTH-1:0]   r_head, w_head_nxt;
    logic                         r_select_error, w_err_nxt;
    logic                         r_timeout_drop, w_drop_nxt;
    logic                         w_ready, w_valid, w_fire, w_legal;
    logic                         w_push, w_pop, w_stalled, w_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_EMPTY;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_stall        <= '0;
            r_head         <= '0;
            r_select_error <= 1'b0;
            r_timeout_drop <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_stall        <= w_stall_nxt;
            r_head         <= w_head_nxt;
            r_select_error <= w_err_nxt;
            r_timeout_drop <= w_drop_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= item_select;
        end
    end

    always_comb begin
        w_ready      = !rst && (r_state != S_FULL) && !cancel;
        w_valid      = (r_state != S_EMPTY);
        w_fire       = item_select_valid && w_ready;
        w_legal      = ({1'b0, item_select} < c_num_items);
        w_push       = w_fire && w_legal;
        w_stalled    = w_valid && !selection_ready && c_timeout_en;
        w_expire     = w_stalled && (r_stall == c_timeout_last);
        w_pop        = w_valid && (selection_ready || w_expire);

        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        w_stall_nxt  = r_stall;
        w_head_nxt   = r_head;
        w_err_nxt    = 1'b0;
        w_drop_nxt   = 1'b0;
        w_next_state = r_state;

        if (cancel) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
            w_stall_nxt  = '0;
        end else begin
            if (w_push) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
            if (w_pop || !w_valid)
                w_stall_nxt = '0;
            else if (w_stalled)
                w_stall_nxt = r_stall + 16'd1;
            w_err_nxt  = w_fire && !w_legal;
            w_drop_nxt = w_expire;
            // Registered show-ahead head; a fresh write can land on the new head slot.
            if (w_count_nxt != '0)
                w_head_nxt = (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? item_select
                                                                   : r_mem[w_rd_ptr_nxt];
        end

        if (w_count_nxt == '0)
            w_next_state = S_EMPTY;
        else if (w_count_nxt == c_depth)
            w_next_state = S_FULL;
        else
            w_next_state = S_ACTIVE;
    end

    assign item_select_ready = w_ready;
    assign selection_valid   = w_valid;
    assign selected_item     = r_head;
    assign select_error      = r_select_error;
    assign timeout_drop      = r_timeout_drop;
    assign pending_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_item_selector_queue.sv
`default_nettype none
// Testbench for item_selector_queue: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_item_selector_queue;

    localparam int W     = 10;
    localparam int NITEM = 1000;
    localparam int DEPTH = 4;
    localparam int TMO   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  item_select;
    logic          item_select_valid;
    logic          item_select_ready;
    logic          cancel;
    logic [W-1:0]  selected_item;
    logic          selection_valid;
    logic          selection_ready;
    logic          select_error;
    logic          timeout_drop;
    logic [2:0]    pending_count;

    item_selector_queue #(
        .ITEM_ADDR_WIDTH(W),
        .NUM_ITEMS      (NITEM),
        .DEPTH          (DEPTH),
        .TIMEOUT        (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .item_select      (item_select),
        .item_select_valid(item_select_valid),
        .item_select_ready(item_select_ready),
        .cancel           (cancel),
        .selected_item    (selected_item),
        .selection_valid  (selection_valid),
        .selection_ready  (selection_ready),
        .select_error     (select_error),
        .timeout_drop     (timeout_drop),
        .pending_count    (pending_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queue contents, consecutive stall cycles of the head,
    // pulse flags and the last head value shown.
    int mq[$];
    int m_stall;
    int m_last;
    bit m_err, m_drop;
    bit m_pre_ready;
    logic pre_ready;

    typedef struct {
        int sel; bit v; bit r; bit c;
        bit e_ready; int e_cnt; bit e_valid; int e_head; bit e_err; bit e_drop;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_stall = 0;
        m_last  = 0;
        m_err   = 0;
        m_drop  = 0;
    endtask

    task automatic model_step(input int s, input bit v, input bit r, input bit c);
        int  size;
        bit  acc, expire, pop;
        size = mq.size();
        acc  = v && (size < DEPTH) && !c;
        if (c) begin
            mq.delete();
            m_stall = 0;
            m_err   = 0;
            m_drop  = 0;
        end else begin
            expire  = (size > 0) && !r && (TMO != 0) && (m_stall == TMO - 1);
            pop     = (size > 0) && (r || expire);
            m_drop  = expire;
            m_err   = acc && (s >= NITEM);
            if (size == 0 || pop) m_stall = 0;
            else                  m_stall++;
            if (pop) void'(mq.pop_front());
            if (acc && s < NITEM) mq.push_back(s);
        end
        if (mq.size() > 0) m_last = mq[0];
    endtask

    // Entered and left at posedge+1.
    task automatic drive_cycle(input int s, input bit v, input bit r, input bit c);
        item_select       = W'(s);
        item_select_valid = v;
        selection_ready   = r;
        cancel            = c;
        #1;
        pre_ready   = item_select_ready;
        m_pre_ready = (mq.size() < DEPTH) && !c;
        @(posedge clk);
        model_step(s, v, r, c);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " ready"}, int'(pre_ready), int'(m_pre_ready));
        chk({tag, " count"}, int'(pending_count), mq.size());
        chk({tag, " valid"}, int'(selection_valid), int'(mq.size() > 0));
        chk({tag, " head"},  int'(selected_item), m_last);
        chk({tag, " err"},   int'(select_error), int'(m_err));
        chk({tag, " drop"},  int'(timeout_drop), int'(m_drop));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " ready"}, int'(item_select_ready), 0);
        chk({tag, " valid"}, int'(selection_valid), 0);
        chk({tag, " count"}, int'(pending_count), 0);
        chk({tag, " head"},  int'(selected_item), 0);
        chk({tag, " err"},   int'(select_error), 0);
        chk({tag, " drop"},  int'(timeout_drop), 0);
    endtask

    task automatic add(input int s, input bit v, input bit r, input bit c, input bit er,
                       input int cnt, input bit ev, input int hd, input bit err, input bit drp);
        vec_t x;
        x = '{s, v, r, c, er, cnt, ev, hd, err, drp};
        tbl.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; item_select = '0; item_select_valid = 0;
        selection_ready = 0; cancel = 0;
        model_reset();

        //   sel  v  r  c  rdy cnt val head err drop
        // single flow
        add(  10, 1, 1, 0, 1,  1,  1,  10, 0, 0);
        add(   0, 0, 1, 0, 1,  0,  0,  10, 0, 0);
        // ordering / full / drain
        add(  10, 1, 0, 0, 1,  1,  1,  10, 0, 0);
        add(  25, 1, 0, 0, 1,  2,  1,  10, 0, 0);
        add(  50, 1, 0, 0, 1,  3,  1,  10, 0, 0);
        add(   7, 1, 0, 0, 1,  4,  1,  10, 0, 0);
        add(  99, 1, 1, 0, 0,  3,  1,  25, 0, 0);
        add(   0, 0, 1, 0, 1,  2,  1,  50, 0, 0);
        add(   0, 0, 1, 0, 1,  1,  1,   7, 0, 0);
        add(   0, 0, 1, 0, 1,  0,  0,   7, 0, 0);
        // range check
        add(1000, 1, 1, 0, 1,  0,  0,   7, 1, 0);
        add(1023, 1, 1, 0, 1,  0,  0,   7, 1, 0);
        add(   0, 0, 1, 0, 1,  0,  0,   7, 0, 0);
        add( 999, 1, 0, 0, 1,  1,  1, 999, 0, 0);
        add(   0, 0, 1, 0, 1,  0,  0, 999, 0, 0);
        // timeout drop after 4 stall cycles
        add(  25, 1, 0, 0, 1,  1,  1,  25, 0, 0);
        add(   0, 0, 0, 0, 1,  1,  1,  25, 0, 0);
        add(   0, 0, 0, 0, 1,  1,  1,  25, 0, 0);
        add(   0, 0, 0, 0, 1,  1,  1,  25, 0, 0);
        add(   0, 0, 0, 0, 1,  0,  0,  25, 0, 1);
        add(   0, 0, 0, 0, 1,  0,  0,  25, 0, 0);
        // accept on the 4th stall cycle: normal pop, no drop
        add(  25, 1, 0, 0, 1,  1,  1,  25, 0, 0);
        add(   0, 0, 0, 0, 1,  1,  1,  25, 0, 0);
        add(   0, 0, 0, 0, 1,  1,  1,  25, 0, 0);
        add(   0, 0, 0, 0, 1,  1,  1,  25, 0, 0);
        add(   0, 0, 1, 0, 1,  0,  0,  25, 0, 0);
        add(   0, 0, 0, 0, 1,  0,  0,  25, 0, 0);
        // cancel with concurrent request
        add(  10, 1, 0, 0, 1,  1,  1,  10, 0, 0);
        add(  25, 1, 0, 0, 1,  2,  1,  10, 0, 0);
        add(  50, 1, 0, 0, 1,  3,  1,  10, 0, 0);
        add(  50, 1, 0, 1, 0,  0,  0,  10, 0, 0);
        add(   0, 0, 0, 0, 1,  0,  0,  10, 0, 0);
        // cancel coinciding with timeout expiry suppresses the drop
        add(   7, 1, 0, 0, 1,  1,  1,   7, 0, 0);
        add(   0, 0, 0, 0, 1,  1,  1,   7, 0, 0);
        add(   0, 0, 0, 0, 1,  1,  1,   7, 0, 0);
        add(   0, 0, 0, 0, 1,  1,  1,   7, 0, 0);
        add(   0, 0, 0, 1, 0,  0,  0,   7, 0, 0);
        add(   0, 0, 0, 0, 1,  0,  0,   7, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        rst = 1'b0;
        #1;
        chk("ready_after_reset", int'(item_select_ready), 1);

        foreach (tbl[i]) begin
            drive_cycle(tbl[i].sel, tbl[i].v, tbl[i].r, tbl[i].c);
            chk($sformatf("vec%0d ready", i), int'(pre_ready),       int'(tbl[i].e_ready));
            chk($sformatf("vec%0d count", i), int'(pending_count),   tbl[i].e_cnt);
            chk($sformatf("vec%0d valid", i), int'(selection_valid), int'(tbl[i].e_valid));
            chk($sformatf("vec%0d head", i),  int'(selected_item),   tbl[i].e_head);
            chk($sformatf("vec%0d err", i),   int'(select_error),    int'(tbl[i].e_err));
            chk($sformatf("vec%0d drop", i),  int'(timeout_drop),    int'(tbl[i].e_drop));
        end

        // Pointer wrap with simultaneous push and pop.
        drive_cycle(100, 1, 0, 0);
        chk("wrap_seed count", int'(pending_count), 1);
        for (int k = 1; k <= 10; k++) begin
            drive_cycle(100 + k, 1, 1, 0);
            chk($sformatf("wrap%0d count", k), int'(pending_count), 1);
            chk($sformatf("wrap%0d head", k),  int'(selected_item), 100 + k);
            chk($sformatf("wrap%0d valid", k), int'(selection_valid), 1);
        end
        drive_cycle(0, 0, 1, 0);
        chk("wrap_drain count", int'(pending_count), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int  s;
            bit  v, r, c;
            s = ($urandom % 8 == 0) ? 1000 + int'($urandom_range(0, 23))
                                    : int'($urandom_range(0, 999));
            v = ($urandom % 4) != 0;
            r = ($urandom % 3) == 0;
            c = ($urandom % 32) == 0;
            drive_cycle(s, v, r, c);
            check_model($sformatf("rnd%0d", n));
        end

        // Asynchronous reset mid-stream, between edges.
        drive_cycle(5, 1, 0, 0);
        drive_cycle(6, 1, 0, 0);
        chk("pre_rst count", int'(pending_count), mq.size());
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("post_rst ready", int'(item_select_ready), 1);
        @(posedge clk);
        #1;
        drive_cycle(3, 1, 1, 0);
        check_model("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
